sram_bus_ctrl: RTL and testbench

Memory-side bus controller sitting directly downstream of the MEM stage and alongside IF. It takes the instruction-fetch request and the MEM stage's data request (address, write data, byte select, chip enable, write enable) and serialises them onto the two external 32-bit SRAMs (base RAM, ext RAM). It generates the multi-cycle SRAM strobes, arbitrates when both requests target the same RAM, and holds the pipeline via `stall_o` until the accesses complete.

---
 rtl/sram_bus_ctrl_if.sv | 23 ++
 rtl/sram_bus_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sram_bus_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_ctrl_if.sv
// Pipeline-side request/response bundle for sram_bus_ctrl.
// The pipeline is the master; the controller is the slave.
interface sram_bus_ctrl_if;
    logic [31:0] if_addr_i;
    logic        if_ce_i;
    logic [31:0] if_rdata_o;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_rdata_o;
    logic        stall_o;

    modport master (
        output if_addr_i, if_ce_i, mem_addr_i, mem_wdata_i, mem_sel_i, mem_ce_i, mem_we_i,
        input  if_rdata_o, mem_rdata_o, stall_o
    );
    modport slave (
        input  if_addr_i, if_ce_i, mem_addr_i, mem_wdata_i, mem_sel_i, mem_ce_i, mem_we_i,
        output if_rdata_o, mem_rdata_o, stall_o
    );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Serialises IF and MEM requests onto the base/ext SRAMs with multi-cycle strobes.
// MEM is served first; a fetch to the same RAM follows in a second phase.
module sram_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    sram_bus_ctrl_if.slave bus,
    inout  wire  [31:0]    base_ram_data,
    output logic [19:0]    base_ram_addr,
    output logic [3:0]     base_ram_be_n,
    output logic           base_ram_ce_n,
    output logic           base_ram_oe_n,
    output logic           base_ram_we_n,
    inout  wire  [31:0]    ext_ram_data,
    output logic [19:0]    ext_ram_addr,
    output logic [3:0]     ext_ram_be_n,
    output logic           ext_ram_ce_n,
    output logic           ext_ram_oe_n,
    output logic           ext_ram_we_n
);
    typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        last;

    logic        if_req, if_map, if_ext;
    logic [19:0] if_word;
    logic        mem_req, mem_map, mem_ext, mem_we;
    logic [19:0] mem_word;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        conflict;

    logic        req_any, if_hit, mem_hit;
    logic [1:0]  mem_on, if_on;
    logic [1:0]  ce_n, oe_n, we_n, drv;
    logic [3:0]  be_n    [2];
    logic [19:0] addr    [2];
    logic [31:0] rd_data [2];
    logic        unused_addr_bits;

    assign req_any = bus.if_ce_i | bus.mem_ce_i;
    // Both RAMs sit in 0x8000_0000..0x807F_FFFF; bit 22 selects ext over base.
    assign if_hit  = bus.if_addr_i[31:23] == 9'h100;
    assign mem_hit = bus.mem_addr_i[31:23] == 9'h100;
    assign last    = cnt == LAST_CNT;
    assign rd_data[0] = base_ram_data;
    assign rd_data[1] = ext_ram_data;
    assign unused_addr_bits = ^{bus.if_addr_i[1:0], bus.mem_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= ((state == PH1 || state == PH2) && !last) ? cnt + 4'd1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_any) state_nx = PH1;
            PH1:     if (last) state_nx = conflict ? PH2 : DONE;
            PH2:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_req    <= 1'b0;
            if_map    <= 1'b0;
            if_ext    <= 1'b0;
            if_word   <= '0;
            mem_req   <= 1'b0;
            mem_map   <= 1'b0;
            mem_ext   <= 1'b0;
            mem_we    <= 1'b0;
            mem_word  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            conflict  <= 1'b0;
        end else if (state == IDLE && req_any) begin
            if_req    <= bus.if_ce_i;
            if_map    <= bus.if_ce_i & if_hit;
            if_ext    <= bus.if_addr_i[22];
            if_word   <= bus.if_addr_i[21:2];
            mem_req   <= bus.mem_ce_i;
            mem_map   <= bus.mem_ce_i & mem_hit;
            mem_ext   <= bus.mem_addr_i[22];
            mem_we    <= bus.mem_we_i;
            mem_word  <= bus.mem_addr_i[21:2];
            mem_wdata <= bus.mem_wdata_i;
            mem_sel   <= bus.mem_sel_i;
            conflict  <= bus.if_ce_i & if_hit & bus.mem_ce_i & mem_hit &
                         (bus.if_addr_i[22] == bus.mem_addr_i[22]);
        end
    end

    // Unmapped loads still complete, returning zero into their register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.if_rdata_o  <= '0;
            bus.mem_rdata_o <= '0;
        end else if (state == PH1 && last) begin
            if (mem_req && !mem_we) bus.mem_rdata_o <= mem_map ? rd_data[mem_ext] : '0;
            if (if_req && !conflict) bus.if_rdata_o <= if_map ? rd_data[if_ext] : '0;
        end else if (state == PH2 && last) begin
            bus.if_rdata_o <= rd_data[if_ext];
        end
    end

    always_comb begin
        mem_on = '0;
        if_on  = '0;
        if (state == PH1) begin
            if (mem_map) mem_on[mem_ext] = 1'b1;
            if (if_map && !conflict) if_on[if_ext] = 1'b1;
        end else if (state == PH2) begin
            if (if_map) if_on[if_ext] = 1'b1;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            ce_n[i] = 1'b1;
            oe_n[i] = 1'b1;
            we_n[i] = 1'b1;
            drv[i]  = 1'b0;
            be_n[i] = '1;
            addr[i] = '0;
            if (mem_on[i]) begin
                ce_n[i] = 1'b0;
                be_n[i] = ~mem_sel;
                addr[i] = mem_word;
                if (mem_we) begin
                    // First write cycle is address setup only.
                    drv[i]  = 1'b1;
                    we_n[i] = (cnt == '0);
                end else begin
                    oe_n[i] = 1'b0;
                end
            end else if (if_on[i]) begin
                ce_n[i] = 1'b0;
                oe_n[i] = 1'b0;
                be_n[i] = '0;
                addr[i] = if_word;
            end
        end
        bus.stall_o = !rst && (state == PH1 || state == PH2 || (state == IDLE && req_any));
    end

    assign base_ram_ce_n = ce_n[0];
    assign base_ram_oe_n = oe_n[0];
    assign base_ram_we_n = we_n[0];
    assign base_ram_be_n = be_n[0];
    assign base_ram_addr = addr[0];
    assign base_ram_data = drv[0] ? mem_wdata : 'z;

    assign ext_ram_ce_n  = ce_n[1];
    assign ext_ram_oe_n  = oe_n[1];
    assign ext_ram_we_n  = we_n[1];
    assign ext_ram_be_n  = be_n[1];
    assign ext_ram_addr  = addr[1];
    assign ext_ram_data  = drv[1] ? mem_wdata : 'z;
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: transaction-level model of the expected
// per-cycle strobes and read data, plus behavioural SRAMs on both buses.
module tb_sram_bus_ctrl;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_bus_ctrl_if bus();

    wire  [31:0] base_ram_data, ext_ram_data;
    logic [19:0] base_ram_addr, ext_ram_addr;
    logic [3:0]  base_ram_be_n, ext_ram_be_n;
    logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

    sram_bus_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
        .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
        .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
        .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
    );

    // ---------------- behavioural SRAMs ----------------
    logic [31:0] sram    [2][256];
    logic [31:0] ref_mem [2][256];
    logic        load_sram = 1'b1;

    function automatic logic [31:0] init_word(input int r, input int i);
        if (r == 0 && i == 0)    return 32'h3C01_1234;
        if (r == 0 && i == 4)    return 32'h2402_0005;
        if (r == 0 && i == 8)    return 32'h0BAD_C0DE;
        if (r == 0 && i == 'h40) return 32'hDEAD_BEEF;
        if (r == 1 && i == 1)    return 32'h1122_3344;
        return 32'(i) * 32'h0101_0101 + 32'(r);
    endfunction

    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n && base_ram_we_n) ? sram[0][base_ram_addr[7:0]] : 'z;
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n && ext_ram_we_n) ? sram[1][ext_ram_addr[7:0]] : 'z;

    always @(posedge clk) begin
        if (load_sram) begin
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < 256; i++) sram[r][i] <= init_word(r, i);
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[b])
                    sram[0][base_ram_addr[7:0]][b*8 +: 8] <= base_ram_data[b*8 +: 8];
                if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[b])
                    sram[1][ext_ram_addr[7:0]][b*8 +: 8] <= ext_ram_data[b*8 +: 8];
            end
        end
    end

    // ---------------- checking ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Current transaction as the model sees it
    logic        t_if_map, t_mem_map, t_mem_we, t_conf;
    int          t_if_tgt, t_mem_tgt, total, if_first;
    logic [19:0] t_if_word, t_mem_word;
    logic [31:0] t_wdata;
    logic [3:0]  t_sel;
    int          k_now = -1;
    int          test_id = 0;

    logic        exp_on = 1'b0;
    logic        exp_stall, exp_rd_chk, chk_idle_addr = 1'b0;
    logic [6:0]  exp_strb [2];
    logic        exp_act  [2];
    logic        exp_drv  [2];
    logic [19:0] exp_addr [2];
    logic [31:0] exp_if_rd, exp_mem_rd;

    logic [6:0]  act_strb [2];
    logic [19:0] act_addr [2];
    logic [31:0] act_data [2];
    string       rn [2] = '{"base", "ext"};
    assign act_strb[0] = {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_be_n};
    assign act_strb[1] = {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_ram_be_n};
    assign act_addr[0] = base_ram_addr;
    assign act_addr[1] = ext_ram_addr;
    assign act_data[0] = base_ram_data;
    assign act_data[1] = ext_ram_data;

    function automatic logic in_ram(input logic [31:0] a);
        return a >= 32'h8000_0000 && a < 32'h8080_0000;
    endfunction
    function automatic int tgt_of(input logic [31:0] a);
        return (a >= 32'h8040_0000) ? 1 : 0;
    endfunction
    function automatic int word_of(input logic [31:0] a);
        return int'((a - ((a >= 32'h8040_0000) ? 32'h8040_0000 : 32'h8000_0000)) >> 2);
    endfunction

    // Expected pin state of each RAM k cycles after the request is seen in IDLE.
    task automatic plan_cycle(input int k);
        for (int r = 0; r < 2; r++) begin
            exp_strb[r] = 7'h7F;
            exp_act[r]  = 1'b0;
            exp_drv[r]  = 1'b0;
            exp_addr[r] = '0;
            if (t_mem_map && t_mem_tgt == r && k >= 1 && k <= W) begin
                exp_act[r]  = 1'b1;
                exp_addr[r] = t_mem_word;
                if (t_mem_we) begin
                    exp_drv[r]  = 1'b1;
                    exp_strb[r] = {1'b0, 1'b1, (k == 1), ~t_sel};
                end else begin
                    exp_strb[r] = {1'b0, 1'b0, 1'b1, ~t_sel};
                end
            end else if (t_if_map && t_if_tgt == r && k >= if_first && k < if_first + W) begin
                exp_act[r]  = 1'b1;
                exp_addr[r] = t_if_word;
                exp_strb[r] = {1'b0, 1'b0, 1'b1, 4'b0000};
            end
        end
        exp_stall  = (k <= total);
        exp_rd_chk = (k == total + 1);
    endtask

    task automatic set_idle_exp();
        t_if_map  = 1'b0;
        t_mem_map = 1'b0;
        total     = -2;
        test_id   = 0;
        k_now     = -1;
        plan_cycle(0);
        exp_stall  = 1'b0;
        exp_rd_chk = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("stall", 32'(bus.stall_o), 32'(exp_stall));
            for (int r = 0; r < 2; r++) begin
                chk({rn[r], "_strobes"}, 32'(act_strb[r]), 32'(exp_strb[r]));
                if (exp_act[r] || chk_idle_addr) chk({rn[r], "_addr"}, 32'(act_addr[r]), 32'(exp_addr[r]));
                if (exp_drv[r]) chk({rn[r], "_wdata"}, act_data[r], t_wdata);
            end
            if (exp_rd_chk) begin
                chk("if_rdata", bus.if_rdata_o, exp_if_rd);
                chk("mem_rdata", bus.mem_rdata_o, exp_mem_rd);
            end
            // Hand-computed pins for the named scenarios
            if (test_id == 1 && (k_now == 1 || k_now == 2)) begin
                chk("fetch_addr", 32'(base_ram_addr), 32'd4);
                chk("fetch_oe_n", 32'(base_ram_oe_n), 32'd0);
            end
            if (test_id == 2 && (k_now == 1 || k_now == 2)) begin
                chk("par_ext_be_n", 32'(ext_ram_be_n), 32'(4'b1011));
                chk("par_ext_we_n", 32'(ext_ram_we_n), 32'(k_now == 1));
                chk("par_base_oe_n", 32'(base_ram_oe_n), 32'd0);
            end
            if (test_id == 2 && k_now == 3) chk("par_done_stall", 32'(bus.stall_o), 32'd0);
            if (test_id == 3 && k_now >= 0) begin
                if (k_now == 1 || k_now == 2) chk("cf_ph1_addr", 32'(base_ram_addr), 32'h40);
                if (k_now == 3 || k_now == 4) chk("cf_ph2_addr", 32'(base_ram_addr), 32'h0);
                chk("cf_stall", 32'(bus.stall_o), 32'(k_now < 5));
            end
            if (test_id == 4 && (k_now == 1 || k_now == 2))
                chk("um_strobes", 32'({act_strb[0], act_strb[1]}), 32'h3FFF);
            if (test_id == 4 && k_now == 3) chk("um_done_stall", 32'(bus.stall_o), 32'd0);
        end
    end

    // Issue one request in IDLE and follow it through DONE; returns in the DONE cycle.
    task automatic run_txn(input int id, input logic ice, input logic [31:0] ia,
                           input logic mce, input logic mwe, input logic [31:0] ma,
                           input logic [31:0] wd, input logic [3:0] sel);
        @(posedge clk); #1;
        bus.if_ce_i = ice;  bus.if_addr_i = ia;
        bus.mem_ce_i = mce; bus.mem_we_i = mwe; bus.mem_addr_i = ma;
        bus.mem_wdata_i = wd; bus.mem_sel_i = sel;
        test_id    = id;
        t_if_map   = ice && in_ram(ia);
        t_if_tgt   = tgt_of(ia);
        t_if_word  = 20'(word_of(ia));
        t_mem_map  = mce && in_ram(ma);
        t_mem_tgt  = tgt_of(ma);
        t_mem_word = 20'(word_of(ma));
        t_mem_we   = mwe;
        t_wdata    = wd;
        t_sel      = sel;
        t_conf     = t_if_map && t_mem_map && (t_if_tgt == t_mem_tgt);
        total      = t_conf ? 2 * W : W;
        if_first   = t_conf ? W + 1 : 1;
        if (t_mem_map && mwe)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[t_mem_tgt][word_of(ma) % 256][b*8 +: 8] = wd[b*8 +: 8];
        if (mce && !mwe) exp_mem_rd = t_mem_map ? ref_mem[t_mem_tgt][word_of(ma) % 256] : 32'h0;
        if (ice) exp_if_rd = t_if_map ? ref_mem[t_if_tgt][word_of(ia) % 256] : 32'h0;
        for (int k = 0; k <= total + 1; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            k_now = k;
            plan_cycle(k);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.if_ce_i = 1'b0;
            bus.mem_ce_i = 1'b0;
            bus.mem_we_i = 1'b0;
            set_idle_exp();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.if_ce_i = 1'b0;  bus.if_addr_i = '0;
        bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
        bus.mem_wdata_i = '0; bus.mem_sel_i = '0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 256; i++) ref_mem[r][i] = init_word(r, i);
        exp_if_rd = '0;
        exp_mem_rd = '0;

        @(posedge clk); #1;
        load_sram = 1'b0;
        set_idle_exp();
        chk_idle_addr = 1'b1;
        exp_on = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle_addr = 1'b0;

        run_txn(1, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("fetch_only_rdata", bus.if_rdata_o, 32'h2402_0005);
        run_txn(2, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'h8040_0006, 32'h00A5_0000, 4'b0100);
        chk("par_if_rdata", bus.if_rdata_o, 32'h3C01_1234);
        run_txn(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8040_0004, 32'h0, 4'b0011);
        chk("par_store_readback", bus.mem_rdata_o, 32'h11A5_3344);
        idle(1);
        run_txn(3, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
        chk("cf_mem_rdata", bus.mem_rdata_o, 32'hDEAD_BEEF);
        chk("cf_if_rdata", bus.if_rdata_o, 32'h3C01_1234);
        idle(2);
        run_txn(4, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 4'hF);
        run_txn(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'hF);
        chk("um_load_rdata", bus.mem_rdata_o, 32'h0);
        run_txn(0, 1'b1, 32'h8040_0008, 1'b1, 1'b1, 32'h8040_0008, 32'h5566_7788, 4'hF);
        chk("store_then_fetch", bus.if_rdata_o, 32'h5566_7788);
        run_txn(0, 1'b1, 32'h8040_0008, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
        chk("split_mem_rdata", bus.mem_rdata_o, 32'h2402_0005);

        // Reset during the first PH1 cycle of a store
        @(posedge clk); #1;
        exp_on = 1'b0;
        bus.if_ce_i = 1'b0;
        bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h8000_0020;
        bus.mem_wdata_i = 32'hCAFE_F00D; bus.mem_sel_i = 4'hF;
        @(posedge clk); #1;
        chk("rst_ph1_ce_n", 32'(base_ram_ce_n), 32'd0);
        rst = 1'b1;
        bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0;
        #1;
        chk("rst_stall_forced", 32'(bus.stall_o), 32'd0);
        @(posedge clk); #1;
        chk("rst_strobes", 32'({act_strb[0], act_strb[1]}), 32'h3FFF);
        chk("rst_base_addr", 32'(base_ram_addr), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("rst_mem_rdata", bus.mem_rdata_o, 32'h0);
        rst = 1'b0;
        exp_if_rd = '0;
        exp_mem_rd = '0;
        set_idle_exp();
        exp_on = 1'b1;

        run_txn(0, 1'b1, 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'hF);
        chk("post_rst_load", bus.mem_rdata_o, 32'h0BAD_C0DE);
        run_txn(0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("um_fetch_rdata", bus.if_rdata_o, 32'h0);
        idle(3);
        exp_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
